// File: rtl/rv64g_l2_dir_store.sv
// L2 coherence directory storage: per-way {valid, sharers, owner, dirty} per set, with a sweep that clears every set after reset.
// Latency: read data one cycle after an accepted request; same-set write-first bypass; writes are a one-cycle read-modify-write.
// Backpressure: none; requests and updates are ignored until init_done_o rises, afterwards one read and one update per cycle.
module rv64g_l2_dir_store #(
  parameter int SETS  = 256,
  parameter int WAYS  = 16,
  parameter int CORES = 4,
  localparam int OWNER_ID_W = $clog2(CORES),
  localparam int SET_W      = $clog2(SETS),
  localparam int WAY_W      = $clog2(WAYS)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  output logic                        init_done_o,
  input  logic                        rd_req_i,
  input  logic [SET_W-1:0]            rd_set_i,
  output logic                        rd_vld_o,
  output logic [WAYS-1:0]             rd_valid_o,
  output logic [WAYS*CORES-1:0]       rd_sharers_o,
  output logic [WAYS-1:0]             rd_owner_valid_o,
  output logic [WAYS*OWNER_ID_W-1:0]  rd_owner_id_o,
  output logic [WAYS-1:0]             rd_dirty_o,
  input  logic                        we_i,
  input  logic [1:0]                  wr_op_i,
  input  logic [SET_W-1:0]            wr_set_i,
  input  logic [WAY_W-1:0]            wr_way_i,
  input  logic [OWNER_ID_W-1:0]       wr_core_i,
  input  logic                        wr_valid_i,
  input  logic [CORES-1:0]            wr_sharers_i,
  input  logic                        wr_owner_valid_i,
  input  logic [OWNER_ID_W-1:0]       wr_owner_id_i,
  input  logic                        wr_dirty_i
);

  localparam logic [1:0] OP_FULL   = 2'b00;
  localparam logic [1:0] OP_ADD    = 2'b01;
  localparam logic [1:0] OP_REMOVE = 2'b10;
  localparam logic [1:0] OP_INVAL  = 2'b11;

  typedef struct packed {
    logic                  valid;
    logic [CORES-1:0]      sharers;
    logic                  owner_valid;
    logic [OWNER_ID_W-1:0] owner_id;
    logic                  dirty;
  } entry_t;

  typedef entry_t [WAYS-1:0] set_t;

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_t;

  set_t             r_mem [SETS];
  state_t           r_state;
  logic [SET_W-1:0] r_cnt;
  logic             r_init_done;
  logic             r_rd_vld;
  set_t             r_rd_dat;

  logic             w_rd_en;
  logic             w_wr_en;
  set_t             w_old_set;
  entry_t           w_old;
  entry_t           w_op;
  entry_t           w_new;
  set_t             w_new_set;
  logic [CORES-1:0] w_core_oh;
  logic [CORES-1:0] w_owner_oh;

  // Traffic is only accepted once the clearing sweep has finished.
  always_comb begin
    w_rd_en = rd_req_i && (r_state == ST_READY);
    w_wr_en = we_i && (r_state == ST_READY);
  end

  // Fetch the old set/entry and decode the core ids to one-hot masks.
  always_comb begin
    w_old_set  = r_mem[wr_set_i];
    w_old      = w_old_set[wr_way_i];
    w_core_oh  = '0;
    w_core_oh[wr_core_i] = 1'b1;
    w_owner_oh = '0;
    w_owner_oh[w_old.owner_id] = 1'b1;
  end

  // Apply the requested operation to the addressed entry.
  always_comb begin
    w_op = w_old;
    case (wr_op_i)
      OP_FULL: begin
        w_op.valid       = wr_valid_i;
        w_op.sharers     = wr_sharers_i;
        w_op.owner_valid = wr_owner_valid_i;
        w_op.owner_id    = wr_owner_id_i;
        w_op.dirty       = wr_dirty_i;
      end
      OP_ADD: begin
        // An existing owner is demoted to a sharer; its dirty data has already been written back.
        w_op.valid   = 1'b1;
        w_op.sharers = w_old.sharers | w_core_oh;
        if (w_old.owner_valid) begin
          w_op.sharers     = w_old.sharers | w_core_oh | w_owner_oh;
          w_op.owner_valid = 1'b0;
          w_op.dirty       = 1'b0;
        end
      end
      OP_REMOVE: begin
        w_op.sharers = w_old.sharers & ~w_core_oh;
        if (w_old.owner_valid && (w_old.owner_id == wr_core_i)) begin
          w_op.owner_valid = 1'b0;
          w_op.dirty       = 1'b0;
        end
      end
      OP_INVAL: begin
        w_op = '0;
      end
      default: begin
        w_op = w_old;
      end
    endcase
  end

  // Enforce the coherence invariants and splice the entry back into its set.
  always_comb begin
    w_new = w_op;
    if (w_new.dirty) begin
      w_new.owner_valid = 1'b1;
    end
    if (w_new.owner_valid) begin
      w_new.sharers = '0;
    end
    w_new_set = w_old_set;
    w_new_set[wr_way_i] = w_new;
  end

  // Sweep/init control: clears one set per cycle, then serves traffic.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_INIT;
      r_cnt       <= '0;
      r_init_done <= 1'b0;
    end else begin
      case (r_state)
        ST_INIT: begin
          r_cnt <= r_cnt + SET_W'(1);
          if (r_cnt == SET_W'(SETS - 1)) begin
            r_state     <= ST_READY;
            r_init_done <= 1'b1;
          end
        end
        ST_READY: begin
          r_init_done <= 1'b1;
        end
        default: begin
          r_state <= ST_INIT;
        end
      endcase
    end
  end

  // Storage array: the sweep clears whole sets, updates touch only the addressed way.
  always_ff @(posedge clk) begin
    if (r_state == ST_INIT) begin
      r_mem[r_cnt] <= '0;
    end else if (w_wr_en) begin
      r_mem[wr_set_i][wr_way_i] <= w_new;
    end
  end

  // Registered read port; a same-set update in the same cycle is forwarded (write-first).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_vld <= 1'b0;
      r_rd_dat <= '0;
    end else begin
      r_rd_vld <= w_rd_en;
      if (w_rd_en) begin
        if (w_wr_en && (wr_set_i == rd_set_i)) begin
          r_rd_dat <= w_new_set;
        end else begin
          r_rd_dat <= r_mem[rd_set_i];
        end
      end
    end
  end

  // Flatten the registered set into the per-field output buses.
  always_comb begin
    rd_valid_o       = '0;
    rd_sharers_o     = '0;
    rd_owner_valid_o = '0;
    rd_owner_id_o    = '0;
    rd_dirty_o       = '0;
    for (int w = 0; w < WAYS; w++) begin
      rd_valid_o[w]                            = r_rd_dat[w].valid;
      rd_sharers_o[w*CORES +: CORES]           = r_rd_dat[w].sharers;
      rd_owner_valid_o[w]                      = r_rd_dat[w].owner_valid;
      rd_owner_id_o[w*OWNER_ID_W +: OWNER_ID_W] = r_rd_dat[w].owner_id;
      rd_dirty_o[w]                            = r_rd_dat[w].dirty;
    end
  end

  assign init_done_o = r_init_done;
  assign rd_vld_o    = r_rd_vld;

endmodule

// File: tb/tb_rv64g_l2_dir_store.sv
module tb_rv64g_l2_dir_store;

  logic        clk;
  logic        rst_n;
  logic        init_done_o;
  logic        rd_req_i;
  logic [7:0]  rd_set_i;
  logic        rd_vld_o;
  logic [15:0] rd_valid_o;
  logic [63:0] rd_sharers_o;
  logic [15:0] rd_owner_valid_o;
  logic [31:0] rd_owner_id_o;
  logic [15:0] rd_dirty_o;
  logic        we_i;
  logic [1:0]  wr_op_i;
  logic [7:0]  wr_set_i;
  logic [3:0]  wr_way_i;
  logic [1:0]  wr_core_i;
  logic        wr_valid_i;
  logic [3:0]  wr_sharers_i;
  logic        wr_owner_valid_i;
  logic [1:0]  wr_owner_id_i;
  logic        wr_dirty_i;

  rv64g_l2_dir_store #(.SETS(256), .WAYS(16), .CORES(4)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .init_done_o      (init_done_o),
    .rd_req_i         (rd_req_i),
    .rd_set_i         (rd_set_i),
    .rd_vld_o         (rd_vld_o),
    .rd_valid_o       (rd_valid_o),
    .rd_sharers_o     (rd_sharers_o),
    .rd_owner_valid_o (rd_owner_valid_o),
    .rd_owner_id_o    (rd_owner_id_o),
    .rd_dirty_o       (rd_dirty_o),
    .we_i             (we_i),
    .wr_op_i          (wr_op_i),
    .wr_set_i         (wr_set_i),
    .wr_way_i         (wr_way_i),
    .wr_core_i        (wr_core_i),
    .wr_valid_i       (wr_valid_i),
    .wr_sharers_i     (wr_sharers_i),
    .wr_owner_valid_i (wr_owner_valid_i),
    .wr_owner_id_i    (wr_owner_id_i),
    .wr_dirty_i       (wr_dirty_i)
  );

  typedef struct {
    logic [15:0] v;
    logic [63:0] sh;
    logic [15:0] ov;
    logic [31:0] id;
    logic [15:0] d;
    int          cyc;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_err = 0;
  int   cyc   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic exp_t zexp();
    exp_t e;
    e.v = '0; e.sh = '0; e.ov = '0; e.id = '0; e.d = '0; e.cyc = 0;
    return e;
  endfunction

  function automatic exp_t put(input exp_t ein, input int w, input logic v, input logic [3:0] sh,
                               input logic ov, input logic [1:0] id, input logic d);
    exp_t e;
    e = ein;
    e.v[w] = v;
    e.sh[w*4 +: 4] = sh;
    e.ov[w] = ov;
    e.id[w*2 +: 2] = id;
    e.d[w] = d;
    return e;
  endfunction

  // Monitor: every read-valid pops one expected set from the scoreboard.
  always @(negedge clk) begin
    if (rst_n && rd_vld_o) begin
      if (q.size() == 0) begin
        n_chk++;
        n_err++;
        $display("FAIL rd_unexpected: got rd_vld_o=1 at cycle %0d expected no read data", cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("rd_latency", 64'(cyc), 64'(e.cyc));
        chk("rd_valid", 64'(rd_valid_o), 64'(e.v));
        chk("rd_sharers", rd_sharers_o, e.sh);
        chk("rd_owner_valid", 64'(rd_owner_valid_o), 64'(e.ov));
        chk("rd_owner_id", 64'(rd_owner_id_o), 64'(e.id));
        chk("rd_dirty", 64'(rd_dirty_o), 64'(e.d));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_wr(input logic [1:0] op, input logic [7:0] s, input logic [3:0] w, input logic [1:0] core,
                        input logic v, input logic [3:0] sh, input logic ov, input logic [1:0] id, input logic d);
    we_i = 1'b1; wr_op_i = op; wr_set_i = s; wr_way_i = w; wr_core_i = core;
    wr_valid_i = v; wr_sharers_i = sh; wr_owner_valid_i = ov; wr_owner_id_i = id; wr_dirty_i = d;
  endtask

  task automatic set_rd(input logic [7:0] s, input exp_t e);
    exp_t ee;
    ee = e;
    ee.cyc = cyc + 1;
    rd_req_i = 1'b1;
    rd_set_i = s;
    q.push_back(ee);
  endtask

  task automatic go();
    tick();
    we_i = 1'b0;
    rd_req_i = 1'b0;
  endtask

  task automatic wr(input logic [1:0] op, input logic [7:0] s, input logic [3:0] w, input logic [1:0] core,
                    input logic v, input logic [3:0] sh, input logic ov, input logic [1:0] id, input logic d);
    set_wr(op, s, w, core, v, sh, ov, id, d);
    go();
  endtask

  task automatic rd(input logic [7:0] s, input exp_t e);
    set_rd(s, e);
    go();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e3;
    exp_t e;
    rst_n = 1'b1;
    rd_req_i = 0; rd_set_i = 0; we_i = 0; wr_op_i = 0; wr_set_i = 0; wr_way_i = 0; wr_core_i = 0;
    wr_valid_i = 0; wr_sharers_i = 0; wr_owner_valid_i = 0; wr_owner_id_i = 0; wr_dirty_i = 0;
    #1 rst_n = 1'b0;
    tick(); tick();
    chk("reset_init_done", 64'(init_done_o), 64'd0);
    chk("reset_rd_vld", 64'(rd_vld_o), 64'd0);
    chk("reset_rd_valid", 64'(rd_valid_o), 64'd0);
    chk("reset_rd_sharers", rd_sharers_o, 64'd0);

    // Sweep with read requests present: none may be answered.
    rst_n = 1'b1;
    rd_req_i = 1'b1; rd_set_i = 8'd3;
    for (int i = 0; i < 255; i++) tick();
    chk("sweep_not_done", 64'(init_done_o), 64'd0);
    rd_req_i = 1'b0;
    tick();
    chk("sweep_done", 64'(init_done_o), 64'd1);

    rd(8'd255, zexp());

    // FULL write: dirty forces ownership, ownership clears sharers.
    wr(2'b00, 8'd3, 4'd5, 2'd0, 1'b1, 4'b0110, 1'b0, 2'd2, 1'b1);
    e3 = put(zexp(), 5, 1'b1, 4'b0000, 1'b1, 2'd2, 1'b1);
    rd(8'd3, e3);

    // ADD on an empty neighbour way leaves way 5 untouched.
    wr(2'b01, 8'd3, 4'd6, 2'd3, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0);
    e3 = put(e3, 6, 1'b1, 4'b1000, 1'b0, 2'd0, 1'b0);
    rd(8'd3, e3);

    // Owner demotion, removals and invalidate on set 7 way 0.
    wr(2'b00, 8'd7, 4'd0, 2'd0, 1'b1, 4'b0000, 1'b1, 2'd2, 1'b1);
    wr(2'b01, 8'd7, 4'd0, 2'd1, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0);
    rd(8'd7, put(zexp(), 0, 1'b1, 4'b0110, 1'b0, 2'd2, 1'b0));
    wr(2'b10, 8'd7, 4'd0, 2'd1, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0);
    rd(8'd7, put(zexp(), 0, 1'b1, 4'b0100, 1'b0, 2'd2, 1'b0));
    wr(2'b10, 8'd7, 4'd0, 2'd2, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0);
    rd(8'd7, put(zexp(), 0, 1'b1, 4'b0000, 1'b0, 2'd2, 1'b0));
    wr(2'b11, 8'd7, 4'd0, 2'd0, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0);
    rd(8'd7, zexp());

    // Same-cycle read and write to set 9: write-first.
    e = put(zexp(), 15, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0);
    set_wr(2'b00, 8'd9, 4'd15, 2'd0, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0);
    set_rd(8'd9, e);
    go();

    // Back-to-back reads, then the outputs must hold.
    set_rd(8'd9, e);
    tick();
    set_rd(8'd3, e3);
    go();
    tick(); tick();
    chk("hold_rd_valid", 64'(rd_valid_o), 64'h0060);
    chk("hold_rd_owner_id", 64'(rd_owner_id_o), 64'(e3.id));

    // Mark set 200, then reset in READY and again mid-sweep.
    wr(2'b00, 8'd200, 4'd4, 2'd0, 1'b1, 4'b0001, 1'b0, 2'd0, 1'b0);
    rd(8'd200, put(zexp(), 4, 1'b1, 4'b0001, 1'b0, 2'd0, 1'b0));
    tick(); tick();
    rst_n = 1'b0;
    #1;
    chk("rst_ready_init_done", 64'(init_done_o), 64'd0);
    chk("rst_ready_rd_valid", 64'(rd_valid_o), 64'd0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 100; i++) tick();
    chk("mid_sweep_init_done", 64'(init_done_o), 64'd0);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_init_done", 64'(init_done_o), 64'd0);
    tick();
    rst_n = 1'b1;
    set_wr(2'b00, 8'd0, 4'd0, 2'd0, 1'b1, 4'b0000, 1'b1, 2'd3, 1'b1);
    rd_req_i = 1'b1; rd_set_i = 8'd0;
    for (int i = 0; i < 255; i++) tick();
    chk("resweep_not_done", 64'(init_done_o), 64'd0);
    we_i = 1'b0; rd_req_i = 1'b0;
    tick();
    chk("resweep_done", 64'(init_done_o), 64'd1);
    rd(8'd200, zexp());
    rd(8'd0, zexp());
    tick(); tick(); tick();
    chk("scoreboard_empty", 64'(q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/rv64g_l2_dir_store.md
Name: rv64g_l2_dir_store

Overview:
Second-generation L2 coherence directory storage. It holds per-way {valid, sharers, owner_valid, owner_id, dirty} for every set, with reads through a registered port. It adds a self-clearing init sweep after reset and atomic read-modify-write sharer operations, and it enforces the coherence invariants on every update. It sits between the L2 coherence controller and the L2 tag/data arrays.

Parameters:
SETS, 256, number of sets; power of two, >=2
WAYS, 16, ways per set; power of two, >=2
CORES, 4, number of tracked cores; power of two, >=2; OWNER_ID_W = $clog2(CORES)

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
init_done_o  output  1  high once the init sweep has completed
rd_req_i  input  1  read request; whole set
rd_set_i  input  $clog2(SETS)  read set index
rd_vld_o  output  1  read data valid, one cycle after an accepted request
rd_valid_o  output  WAYS  per-way valid
rd_sharers_o  output  WAYS*CORES  per-way sharer vectors; way w at [w*CORES +: CORES]
rd_owner_valid_o  output  WAYS  per-way owner valid
rd_owner_id_o  output  WAYS*OWNER_ID_W  per-way owner id
rd_dirty_o  output  WAYS  per-way dirty
we_i  input  1  write/update request
wr_op_i  input  2  00 FULL, 01 ADD_SHARER, 10 REMOVE_SHARER, 11 INVALIDATE
wr_set_i  input  $clog2(SETS)  target set
wr_way_i  input  $clog2(WAYS)  target way
wr_core_i  input  OWNER_ID_W  core for ADD/REMOVE ops
wr_valid_i, wr_sharers_i (CORES), wr_owner_valid_i, wr_owner_id_i (OWNER_ID_W), wr_dirty_i  input  FULL-op data

Behaviour:
- Reset (rst_n low, async):
  - FSM enters INIT with sweep counter 0.
  - init_done_o=0, rd_vld_o=0, all rd_* data outputs 0.
- INIT state:
  - Each cycle writes all-zero to set[counter] and increments the counter.
  - After set SETS-1 is written, FSM moves to READY. init_done_o rises in the cycle after the last set write and stays high.
  - Total sweep length: SETS cycles.
  - we_i and rd_req_i are ignored during INIT; rd_vld_o stays 0.
- Reset asserted mid-sweep or in READY: the sweep restarts from set 0.
- Read (READY):
  - rd_req_i is sampled at a clock edge, and rd_vld_o is high the following cycle with registered set data.
  - rd_vld_o is a single-cycle pulse per request; back-to-back requests give back-to-back valid data.
  - Data outputs hold their last value when rd_vld_o=0.
- Write (READY, we_i=1):
  - Reads the old entry, applies the op, enforces invariants, and writes in the same cycle. Updates are visible to reads sampled on the next edge.
  - FULL: entry = wr_* inputs.
  - ADD_SHARER: valid=1, sharers |= onehot(core). If owner_valid=1, the old owner's bit is also set in sharers, and owner_valid=0, dirty=0. The controller has already written back any dirty data.
  - REMOVE_SHARER: sharers &= ~onehot(core). If owner_valid and owner_id==core, then owner_valid=0 and dirty=0. valid is unchanged.
  - INVALIDATE: entry = all-zero.
- Invariants, applied after the op:
  - dirty forces owner_valid=1.
  - owner_valid=1 forces sharers=0.
  - owner_id is stored unchanged even when owner_valid=0.
- Collision: a read and a write to the same set in the same cycle return the post-write entry (write-first). Other ways are unaffected.
- Only the addressed way is modified; the other WAYS-1 entries are preserved bit-exactly.
- No X on any output after reset.

Test Plan:
- Reset, hold rst_n=1 for SETS-1 cycles -> init_done_o=0. Next cycle -> init_done_o=1. Read set 255 -> all fields 0, rd_vld_o=1 exactly one cycle after rd_req_i.
- FULL write set 3 way 5 {valid=1, sharers=4'b0110, owner_valid=0, dirty=1, id=2} -> read shows valid=1, owner_valid=1, sharers=0, dirty=1, id=2; ways 0-4 and 6-15 are 0.
- FULL write owner core 2 dirty to set 7 way 0, then ADD_SHARER core 1 -> sharers=4'b0110, owner_valid=0, dirty=0.
- REMOVE_SHARER core 1, then core 2, on that entry -> sharers=4'b0100, then 4'b0000; valid stays 1. INVALIDATE -> entry 0.
- Same-cycle rd_req set 9 and FULL write set 9 way 15 valid=1 -> the returned rd_valid_o[15]=1.
- Assert rst_n low mid-sweep at counter 100 with set 200 previously written -> init_done_o drops at once. A fresh SETS-cycle sweep follows, and set 200 then reads 0. we_i during the sweep has no effect.
